// File: rtl/sipo_deser_if.sv
// Bundle of the serial-input and word-output signals of sipo_deser.
// parity_err only exists when SIPO_DESER_PARITY_EN is defined.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             clr;
  logic             sdi;
  logic             sdi_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;
`ifdef SIPO_DESER_PARITY_EN
  logic             parity_err;

  modport master (
    output clr, sdi, sdi_valid, dout_ready,
    input  q_shift, dout, dout_valid, overrun, bit_cnt, parity_err
  );
  modport slave (
    input  clr, sdi, sdi_valid, dout_ready,
    output q_shift, dout, dout_valid, overrun, bit_cnt, parity_err
  );
`else
  modport master (
    output clr, sdi, sdi_valid, dout_ready,
    input  q_shift, dout, dout_valid, overrun, bit_cnt
  );
  modport slave (
    input  clr, sdi, sdi_valid, dout_ready,
    output q_shift, dout, dout_valid, overrun, bit_cnt
  );
`endif
endinterface

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserialiser with a one-word output holding
// register, ready/valid consumption and a sticky overrun flag.
// Optional feature macro: SIPO_DESER_PARITY_EN (adds a trailing even-parity
// bit per frame and the parity_err output).
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         reset_n,
  sipo_deser_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SIPO_DESER_PARITY_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;
`ifdef SIPO_DESER_PARITY_EN
  logic             perr_q, perr_d;
  logic             par;
`endif

  // Shift-register value if the current sdi bit is taken.
  always_comb begin
    if (LSB_FIRST) shifted = {bus.sdi, shift_q[WIDTH-1:1]};
    else           shifted = {shift_q[WIDTH-2:0], bus.sdi};
  end

  // Next-state: frame counting, word completion and output register rules.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    ov_d    = ov_q;
    word    = shifted;
    done    = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    perr_d  = perr_q;
    par     = (^shift_q) ^ bus.sdi;
`endif
    if (bus.clr) begin
      shift_d = '0;
      cnt_d   = '0;
      dout_d  = '0;
      dv_d    = 1'b0;
      ov_d    = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      if (bus.sdi_valid) begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef SIPO_DESER_PARITY_EN
        // parity bit completes the frame but never enters the shift register
        word = shift_q;
        if (cnt_q != LAST_CNT) shift_d = shifted;
`else
        shift_d = shifted;
`endif
      end
      if (done) begin
        if (!dv_q || bus.dout_ready) begin
          dout_d = word;
          dv_d   = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
          perr_d = par;
`endif
        end else begin
          ov_d = 1'b1;
        end
      end else if (dv_q && bus.dout_ready) begin
        dv_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
`ifdef SIPO_DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.q_shift    = shift_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.overrun    = ov_q;
`ifdef SIPO_DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one stimulus
// stream; a frame-level model predicts every output each cycle.
module tb_sipo_deser;
  localparam int unsigned W = 8;
`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif
  localparam int unsigned MASK = 32'hFF;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clr = 1'b0, sdi = 1'b0, sdi_valid = 1'b0, dout_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bus0 ();
  sipo_deser_if #(.WIDTH(W)) bus1 ();

  assign bus0.clr = clr;  assign bus0.sdi = sdi;
  assign bus0.sdi_valid = sdi_valid;  assign bus0.dout_ready = dout_ready;
  assign bus1.clr = clr;  assign bus1.sdi = sdi;
  assign bus1.sdi_valid = sdi_valid;  assign bus1.dout_ready = dout_ready;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // Model: index 0 = MSB-first instance, index 1 = LSB-first instance.
  int unsigned m_q[2];
  int unsigned m_dout[2];
  bit m_dv, m_ov, m_perr;
  bit frame[$];

  always @(posedge clk or negedge reset_n) begin
    bit done;
    bit par;
    int unsigned wd[2];
    if (!reset_n) begin
      m_q = '{0, 0}; m_dout = '{0, 0};
      m_dv = 0; m_ov = 0; m_perr = 0;
      frame.delete();
    end else if (clr) begin
      m_q = '{0, 0}; m_dout = '{0, 0};
      m_dv = 0; m_ov = 0; m_perr = 0;
      frame.delete();
    end else begin
      done = 0; par = 0; wd = '{0, 0};
      if (sdi_valid) begin
        frame.push_back(sdi);
        if (frame.size() <= W) begin
          m_q[0] = ((m_q[0] << 1) | int'(sdi)) & MASK;
          m_q[1] = (m_q[1] >> 1) | (int'(sdi) << (W - 1));
        end
        if (frame.size() == FRAME) begin
          done = 1;
          for (int i = 0; i < FRAME; i++) begin
            par ^= frame[i];
            if (i < W) begin
              wd[0] |= int'(frame[i]) << (W - 1 - i);
              wd[1] |= int'(frame[i]) << i;
            end
          end
          frame.delete();
        end
      end
      if (done) begin
        if (!m_dv || dout_ready) begin
          m_dout = wd; m_dv = 1; m_perr = par;
        end else begin
          m_ov = 1;
        end
      end else if (m_dv && dout_ready) begin
        m_dv = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled after outputs settle.
  always @(posedge clk) begin
    #2;
    check("q_shift0", bus0.q_shift, m_q[0]);
    check("q_shift1", bus1.q_shift, m_q[1]);
    check("bit_cnt0", bus0.bit_cnt, frame.size());
    check("bit_cnt1", bus1.bit_cnt, frame.size());
    check("dout0", bus0.dout, m_dout[0]);
    check("dout1", bus1.dout, m_dout[1]);
    check("dout_valid0", bus0.dout_valid, m_dv);
    check("dout_valid1", bus1.dout_valid, m_dv);
    check("overrun0", bus0.overrun, m_ov);
    check("overrun1", bus1.overrun, m_ov);
`ifdef SIPO_DESER_PARITY_EN
    check("parity_err0", bus0.parity_err, m_perr);
    check("parity_err1", bus1.parity_err, m_perr);
`endif
  end

  task automatic send_bit(input bit b, input bit rdy);
    @(negedge clk);
    sdi = b; sdi_valid = 1'b1; dout_ready = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdi_valid = 1'b0; sdi = ~sdi;
    end
  endtask

  // Send w MSB-first; rdy_last applies on the frame's final bit.
  task automatic send_word(input logic [7:0] w, input bit gap, input bit rdy,
                           input bit rdy_last, input bit pflip);
    bit pb;
    pb = (^w) ^ pflip;
    for (int i = 0; i < 8; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        sdi_valid = 1'b0; sdi = ~sdi; dout_ready = rdy;
      end
`ifdef SIPO_DESER_PARITY_EN
      send_bit(w[7-i], rdy);
`else
      send_bit(w[7-i], (i == 7) ? rdy_last : rdy);
`endif
    end
`ifdef SIPO_DESER_PARITY_EN
    send_bit(pb, rdy_last);
`endif
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q_shift", bus0.q_shift, 32'h0);
    check("rst_dout", bus0.dout, 32'h0);
    check("rst_dout_valid", bus0.dout_valid, 32'h0);
    check("rst_overrun", bus0.overrun, 32'h0);
    check("rst_bit_cnt", bus0.bit_cnt, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
    dout_ready = 1'b1;
    send_word(8'hB2, 1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("b2_dout_msb", bus0.dout, 32'hB2);
    check("b2_dout_lsb", bus1.dout, 32'h4D);
    check("b2_valid", bus0.dout_valid, 32'h1);
    check("b2_bit_cnt", bus0.bit_cnt, 32'h0);
    idle(1);
    after_edge();
    check("b2_valid_one_cycle", bus0.dout_valid, 32'h0);
    idle(2);

    // A5 with idle gaps between accepted bits
    send_word(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("a5_dout_msb", bus0.dout, 32'hA5);
    check("a5_dout_lsb", bus1.dout, 32'hA5);
    idle(3);

    // consumer stalled: second word dropped, overrun sticks
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    check("ovr_dout_msb", bus0.dout, 32'h11);
    check("ovr_dout_lsb", bus1.dout, 32'h88);
    check("ovr_flag", bus0.overrun, 32'h1);
    idle(2);
    check("ovr_sticky", bus0.overrun, 32'h1);

    // clr wins over a simultaneous valid bit and ready
    @(negedge clk);
    clr = 1'b1; sdi_valid = 1'b1; sdi = 1'b1; dout_ready = 1'b1;
    after_edge();
    check("clr_dout", bus0.dout, 32'h0);
    check("clr_valid", bus0.dout_valid, 32'h0);
    check("clr_overrun", bus0.overrun, 32'h0);
    check("clr_q_shift", bus0.q_shift, 32'h0);
    @(negedge clk) clr = 1'b0; sdi_valid = 1'b0;

    // completion on the same edge as consumption reloads and stays valid
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    check("swap_dout", bus0.dout, 32'h5A);
    check("swap_valid", bus0.dout_valid, 32'h1);
    check("swap_overrun", bus0.overrun, 32'h0);
    dout_ready = 1'b1;
    idle(3);

    // reset mid-frame discards partial bits
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b0; sdi_valid = 1'b0;
    #1;
    check("async_rst_q_shift", bus0.q_shift, 32'h0);
    check("async_rst_bit_cnt", bus0.bit_cnt, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    send_word(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("c3_dout_msb", bus0.dout, 32'hC3);
    check("c3_dout_lsb", bus1.dout, 32'hC3);
    idle(2);

`ifdef SIPO_DESER_PARITY_EN
    send_word(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("par_ok_err", bus0.parity_err, 32'h0);
    idle(2);
    send_word(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1);
    after_edge();
    check("par_bad_err", bus0.parity_err, 32'h1);
    check("par_bad_dout", bus0.dout, 32'h0F);
    idle(2);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the deserialised word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0, SHALL select bit order: 0 = first received bit lands in dout[WIDTH-1], 1 = first received bit lands in dout[0].
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 clr  input  1  SHALL be a synchronous, active-high clear of frame state.
REQ-006 sdi  input  1  SHALL be the serial data bit.
REQ-007 sdi_valid  input  1  SHALL qualify sdi; a bit is accepted on a rising edge only when sdi_valid=1.
REQ-008 q_shift  output  WIDTH  SHALL expose the live shift register.
REQ-009 dout  output  WIDTH  SHALL hold the last completed word.
REQ-010 dout_valid  output  1  SHALL flag that dout holds an unconsumed word.
REQ-011 dout_ready  input  1  SHALL indicate that the consumer takes dout on this edge.
REQ-012 overrun  output  1  SHALL be a sticky flag set when a completed word is lost.
REQ-013 bit_cnt  output  $clog2(WIDTH+1)  SHALL expose the count of bits accepted in the current frame.

Function
REQ-014 Accepted bit SHALL shift as follows: LSB_FIRST=0: q_shift <= {q_shift[WIDTH-2:0], sdi}; LSB_FIRST=1: q_shift <= {sdi, q_shift[WIDTH-1:1]}.
REQ-015 With sdi_valid=0, q_shift and bit_cnt SHALL hold.
REQ-016 bit_cnt SHALL increment per accepted data bit; on the edge accepting the final frame bit it SHALL wrap to 0.
REQ-017 On that final-bit edge, dout SHALL load the completed word (including the final bit) and dout_valid SHALL become 1: latency 0 cycles after the edge, visible in the following cycle.
REQ-018 q_shift SHALL continue from its current contents into the next frame; it is not cleared on frame completion.
REQ-019 dout_valid SHALL clear on an edge where dout_valid=1 and dout_ready=1, unless a word completes on the same edge; in that case dout loads the new word and dout_valid stays 1.
REQ-020 If a word completes while dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL hold, and overrun SHALL set.
REQ-021 overrun SHALL remain set until clr or reset.
REQ-022 dout_ready while dout_valid=0 SHALL have no effect.
REQ-023 clr=1 SHALL, on the next edge, zero q_shift, bit_cnt, dout, dout_valid and overrun, taking priority over sdi_valid and dout_ready.

Reset
REQ-024 reset_n=0 SHALL immediately force q_shift=0, dout=0, dout_valid=0, overrun=0, bit_cnt=0 and, if present, parity_err=0, independent of clk.
REQ-025 Reset assertion mid-frame SHALL discard the partial frame; the first accepted bit after release SHALL be bit 0 of a new frame.

Configuration
REQ-026 With macro SIPO_DESER_PARITY_EN defined, the frame SHALL be WIDTH+1 bits, the last being an even-parity bit that is not shifted into q_shift, and bit_cnt SHALL count to WIDTH before wrapping.
REQ-027 With SIPO_DESER_PARITY_EN defined, output parity_err (1 bit) SHALL load together with dout, equal to XOR of the WIDTH data bits and the parity bit, follow the same hold/drop rules as dout, and clear on clr.
REQ-028 Without SIPO_DESER_PARITY_EN, the frame SHALL be WIDTH bits and port parity_err SHALL not exist.

Verification (WIDTH=8, parity disabled unless stated)
REQ-029 LSB_FIRST=0, sdi_valid=1 continuously, bits 1,0,1,1,0,0,1,0 with dout_ready=1 -> dout=8'hB2 and dout_valid=1 for exactly one cycle after the 8th edge; bit_cnt returns to 0.
REQ-030 LSB_FIRST=1, same bit sequence -> dout=8'h4D.
REQ-031 sdi_valid toggling 1,0 every cycle over 16 cycles carrying 8'hA5 MSB-first -> dout=8'hA5 after the 8th accepted bit; q_shift and bit_cnt unchanged on gap cycles.
REQ-032 dout_ready=0, two consecutive frames 8'h11 then 8'h22 -> dout stays 8'h11, overrun=1; clr pulse -> dout=0, dout_valid=0, overrun=0.
REQ-033 reset_n pulsed low after 3 bits of a frame, then 8 bits 8'hC3 -> dout=8'hC3 with no residue from the aborted frame.
REQ-034 SIPO_DESER_PARITY_EN defined: data 8'h0F with parity bit 0 -> parity_err=0; data 8'h0F with parity bit 1 -> parity_err=1, dout=8'h0F.
